// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers used by both the encryption
// and decryption blocks.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} dec_fsm_t;

  // Element 0 is the most significant byte, so SBOX[b] is the substitute of b.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range indices read as zero so idle-state lookups stay defined.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] added;
  logic [127:0] mixed;

  // Byte n sits at row n%4, column n/4; row r rotates right by r positions.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * (((gi / 4) - ROW + 4) % 4) + ROW;
    assign added[127-8*gi -: 8] = INV_SBOX[state_in[127-8*SRC -: 8]]
                                  ^ round_key[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = added[127-32*gi -: 32];
    assign mixed[127-32*gi -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
    };
  end

  assign state_out = last_round ? added : mixed;

endmodule

// File: rtl/decryption_block.sv
// Iterative AES-128 inverse cipher: walks the key schedule forward to the last
// round key, then runs one inverse round per cycle while stepping it back.
module decryption_block
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         decryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  dec_fsm_t   fsm_reg;
  logic [3:0] cnt_reg;
  aes_state_t key_reg;
  aes_state_t data_reg;
  aes_state_t out_reg;
  logic       busy_reg;
  logic       done_reg;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, sw_out;
  logic [7:0]  rcon_val;
  aes_state_t  fwd_key, bwd_key, round_out;

  assign {w0, w1, w2, w3} = key_reg;

  // Forward and backward key steps share one SubWord unit; the backward step
  // feeds it the reconstructed previous w3 (w3 ^ w2) instead of w3.
  assign rcon_val = rcon_at((fsm_reg == INIT) ? LAST_RND : cnt_reg);
  assign sw_in    = (fsm_reg == KEYEXP) ? w3 : (w3 ^ w2);
  assign sw_out   = subword(rotword(sw_in)) ^ {rcon_val, 24'h000000};

  assign fwd_key = {w0 ^ sw_out,
                    w0 ^ w1 ^ sw_out,
                    w0 ^ w1 ^ w2 ^ sw_out,
                    w0 ^ w1 ^ w2 ^ w3 ^ sw_out};
  assign bwd_key = {w0 ^ sw_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  aes_inv_round u_round (
    .state_in  (data_reg),
    .round_key (key_reg),
    .last_round(fsm_reg == FINAL),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg  <= IDLE;
      cnt_reg  <= '0;
      key_reg  <= '0;
      data_reg <= '0;
      out_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (decryptEnable) begin
            key_reg  <= key;
            data_reg <= inputData;
            cnt_reg  <= 4'd1;
            busy_reg <= 1'b1;
            fsm_reg  <= KEYEXP;
          end
        end
        KEYEXP: begin
          key_reg <= fwd_key;
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_RND) fsm_reg <= INIT;
        end
        INIT: begin
          data_reg <= data_reg ^ key_reg;
          key_reg  <= bwd_key;
          cnt_reg  <= LAST_RND - 4'd1;
          fsm_reg  <= ROUND;
        end
        ROUND: begin
          data_reg <= round_out;
          key_reg  <= bwd_key;
          cnt_reg  <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) fsm_reg <= FINAL;
        end
        FINAL: begin
          out_reg  <= round_out;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
          fsm_reg  <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
          fsm_reg  <= IDLE;
        end
      endcase
    end
  end

  assign outputData = out_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule
